// File: rtl/adder_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_arb_seq
// Description : Two-requester arbiter in front of a nibble-serial adder.
//               A granted operation is summed one nibble per cycle on an
//               external shared 4-bit adder; the carry ripples between
//               nibbles through a local register. The result is then held
//               until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arb_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*4*NIBBLES-1:0]   req_a,
  input  logic [2*4*NIBBLES-1:0]   req_b,
  input  logic [1:0]               req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [4*NIBBLES-1:0]     rsp_sum,
  output logic                     rsp_cout,
  output logic [3:0]               add_a,
  output logic [3:0]               add_b,
  output logic                     add_cin,
  input  logic [3:0]               add_sum,
  input  logic                     add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            lp_q, lp_d;          // last granted requester
  logic [KW-1:0]   k_q, k_d;            // nibble currently on the adder
  logic            c_q, c_d;            // carry between nibbles
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            id_q, id_d;
  logic [W-1:0]    result_q, result_d;

  logic            grant;
  logic [KW+1:0]   nib_base;

  assign nib_base = {k_q, 2'b00};

  // Pick a requester: a lone valid wins, a tie goes to the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant = ~lp_q;
    end
  end

  // Next-state and output decode for the IDLE -> ADD -> RESP sequence.
  always_comb begin
    state_d   = state_q;
    lp_d      = lp_q;
    k_d       = k_q;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    result_d  = result_q;
    req_ready = 2'b00;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gating with rst keeps a handshake from being seen during reset.
        if (!rst && (|req_valid)) begin
          req_ready = grant ? 2'b10 : 2'b01;
          lp_d      = grant;
          id_d      = grant;
          a_d       = grant ? req_a[2*W-1:W] : req_a[W-1:0];
          b_d       = grant ? req_b[2*W-1:W] : req_b[W-1:0];
          c_d       = req_cin[grant];
          k_d       = '0;
          state_d   = S_ADD;
        end
      end

      S_ADD: begin
        add_a                  = a_q[nib_base +: 4];
        add_b                  = b_q[nib_base +: 4];
        add_cin                = c_q;
        result_d[nib_base +: 4] = add_sum;
        c_d                    = add_cout;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset also abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lp_q     <= 1'b1;
      k_q      <= '0;
      c_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lp_q     <= lp_d;
      k_q      <= k_d;
      c_q      <= c_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = result_q;
  assign rsp_cout  = c_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arb_seq
// Description : Self-checking bench for adder_arb_seq (NIBBLES=4). Supplies
//               the external 4-bit adder and compares against a plain
//               arithmetic model of arbitration, latency and sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arb_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_sum;
  logic           add_cout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_acc = 0;
  logic m_lp;

  adder_arb_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External combinational 4-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: lone valid wins; tie goes to the requester other than the last grant.
  function automatic logic exp_grant(input logic [1:0] vld);
    if (vld == 2'b01) return 1'b0;
    if (vld == 2'b10) return 1'b1;
    return (m_lp == 1'b1) ? 1'b0 : 1'b1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    tick();
    tick();
    chk("ready_in_reset2", 64'(req_ready), 64'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    m_lp      = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'(rsp_id),    64'd0);
    chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("rst_rsp_cout",  64'(rsp_cout),  64'd0);
    chk("rst_add_a",     64'(add_a),     64'd0);
  endtask

  // One complete transaction; hold = cycles rsp_ready stays low in RESP
  // (ignored when rr_early keeps rsp_ready high throughout).
  task automatic do_op(input logic [1:0] vld, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] cin,
                       input int hold, input logic rr_early, input logic chk_int);
    logic         g;
    logic [W-1:0] ea, eb;
    logic         ec;
    logic [W:0]   full;
    int           acc;
    req_valid = vld;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_cin   = cin;
    rsp_ready = rr_early;
    #1;
    g    = exp_grant(vld);
    ea   = g ? a1 : a0;
    eb   = g ? b1 : b0;
    ec   = cin[g];
    full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    chk("grant", 64'(req_ready), 64'(2'b01 << g));
    tick();
    acc  = cyc;
    m_lp = g;
    if (chk_int) chk("issue_interval", 64'(acc - prev_acc), 64'(NIB + 2));
    prev_acc = acc;
    // Disturb the inputs after accept; the in-flight result must not notice.
    req_a   = {$urandom, $urandom};
    req_b   = {$urandom, $urandom};
    req_cin = 2'($urandom);
    for (int k = 0; k < NIB; k++) begin
      chk("add_a_nib",   64'(add_a), 64'((ea >> (4 * k)) & 16'hF));
      chk("add_b_nib",   64'(add_b), 64'((eb >> (4 * k)) & 16'hF));
      if (k == 0) chk("add_cin0", 64'(add_cin), 64'(ec));
      chk("ready_in_add", 64'(req_ready), 64'd0);
      chk("early_valid",  64'(rsp_valid), 64'd0);
      tick();
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_sum",   64'(rsp_sum),   64'(full[W-1:0]));
    chk("rsp_cout",  64'(rsp_cout),  64'(full[W]));
    chk("rsp_id",    64'(rsp_id),    64'(g));
    chk("add_a_resp", 64'(add_a), 64'd0);
    if (!rr_early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_sum",   64'(rsp_sum),   64'(full[W-1:0]));
        chk("hold_cout",  64'(rsp_cout),  64'(full[W]));
        chk("hold_id",    64'(rsp_id),    64'(g));
        chk("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      #1;
    end
    req_valid = 2'b11;
    #1;
    chk("ready_in_resp", 64'(req_ready), 64'd0);
    tick();
    chk("rsp_dropped", 64'(rsp_valid), 64'd0);
    rsp_ready = rr_early;
  endtask

  initial begin
    logic [1:0] v;
    logic       g;
    logic [W-1:0] ra;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    m_lp      = 1'b1;
    do_reset();

    // Directed sums.
    do_op(2'b01, 16'h0001, 16'h0002, 16'h1234, 16'h4321, 2'b00, 0, 1'b0, 1'b0);
    do_op(2'b10, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0001, 2'b00, 0, 1'b0, 1'b0);
    do_op(2'b01, 16'h0F0F, 16'h00F1, 16'h0000, 16'h0000, 2'b01, 0, 1'b0, 1'b0);
    // Consumer stalls three cycles; next accept right after RESP exit.
    do_op(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'b11, 3, 1'b0, 1'b0);
    do_op(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'b10, 0, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Fresh reset: both requesters continuously valid alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_op(2'b11, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 0, 1'b1, (i > 0));
      chk("alternate_id", 64'(m_lp), 64'(i % 2));
    end
    rsp_ready = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 10; i++) begin
      v = 2'($urandom_range(1, 3));
      do_op(v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
    req_valid = 2'b00;
    #1;

    // Abort in ADD cycle k=2.
    ra        = 16'($urandom);
    req_valid = 2'b10;
    req_a     = {ra, 16'h0000};
    req_b     = {16'h1111, 16'h0000};
    req_cin   = 2'b00;
    #1;
    g = exp_grant(2'b10);
    chk("abort_grant", 64'(req_ready), 64'(2'b01 << g));
    tick();
    m_lp      = g;
    req_valid = 2'b00;
    tick();
    tick();
    chk("abort_nib2", 64'(add_a), 64'((ra >> 8) & 16'hF));
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("abort_ready_rst", 64'(req_ready), 64'd0);
    tick();
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_add_a", 64'(add_a),     64'd0);
    chk("abort_sum",   64'(rsp_sum),   64'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    m_lp      = 1'b1;
    for (int i = 0; i < NIB + 2; i++) begin
      tick();
      chk("no_aborted_rsp", 64'(rsp_valid), 64'd0);
    end
    do_op(2'b11, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 2'b01, 1, 1'b0, 1'b0);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
